cache_fill_arbiter: RTL and testbench

CACHE_FILL_ARBITER -- requirements
Module: cache_fill_arbiter

---
 rtl/cache_fill_arbiter.sv | 129 ++++++++++++
 tb/tb_cache_fill_arbiter.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cache_fill_arbiter.sv
// Arbitrates I-/D-cache miss fills: issues 8 word reads per 16-byte block and
// routes returned words to the granted cache. Define FILL_RR_EN for round-robin arbitration.
module cache_fill_arbiter (
  input  logic        clk,
  input  logic        rst,
  input  logic        imiss_req,
  input  logic [15:0] imiss_addr,
  input  logic        dmiss_req,
  input  logic [15:0] dmiss_addr,
  output logic        mem_en,
  output logic [15:0] mem_addr,
  input  logic        mem_data_valid,
  input  logic [15:0] mem_data,
  output logic        fill_we,
  output logic        fill_sel,
  output logic [2:0]  fill_idx,
  output logic [15:0] fill_data,
  output logic        ifill_done,
  output logic        dfill_done,
  output logic        busy
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_e;

  state_e      state_q;
  logic        fill_sel_q;
  logic [2:0]  issue_cnt_q;
  logic [2:0]  recv_cnt_q;
  logic        mem_en_q;
  logic [15:0] mem_addr_q;
  logic        ifill_done_q;
  logic        dfill_done_q;

  logic        grant_d;
  logic [15:0] grant_base;
  logic        accept;
  logic        last_word;

`ifdef FILL_RR_EN
  logic        prefer_d_q;

  assign grant_d = dmiss_req && (!imiss_req || prefer_d_q);
`else
  assign grant_d = dmiss_req;
`endif

  assign grant_base = (grant_d ? dmiss_addr : imiss_addr) & 16'hFFF0;

  // Returned words are only meaningful while a fill is in flight.
  assign accept    = mem_data_valid && ((state_q == ISSUE) || (state_q == WAIT));
  assign last_word = accept && (recv_cnt_q == 3'd7);

  // NOTE: one clocked block with non-blocking assignments only; the async
  // reset clears every register so outputs fall to idle values immediately.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      fill_sel_q   <= 1'b0;
      issue_cnt_q  <= 3'd0;
      recv_cnt_q   <= 3'd0;
      mem_en_q     <= 1'b0;
      mem_addr_q   <= 16'h0000;
      ifill_done_q <= 1'b0;
      dfill_done_q <= 1'b0;
`ifdef FILL_RR_EN
      prefer_d_q   <= 1'b1;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          if (imiss_req || dmiss_req) begin
            state_q     <= ISSUE;
            fill_sel_q  <= grant_d;
            issue_cnt_q <= 3'd0;
            recv_cnt_q  <= 3'd0;
            mem_en_q    <= 1'b1;
            mem_addr_q  <= grant_base;
`ifdef FILL_RR_EN
            prefer_d_q  <= !grant_d;
`endif
          end
        end
        ISSUE: begin
          issue_cnt_q <= issue_cnt_q + 3'd1;
          if (accept) recv_cnt_q <= recv_cnt_q + 3'd1;
          if (issue_cnt_q == 3'd7) begin
            mem_en_q   <= 1'b0;
            mem_addr_q <= 16'h0000;
          end else begin
            // Base is block aligned, so stepping by 2 never leaves the block.
            mem_addr_q <= mem_addr_q + 16'd2;
          end
          if (last_word) begin
            state_q      <= DONE;
            ifill_done_q <= !fill_sel_q;
            dfill_done_q <= fill_sel_q;
          end else if (issue_cnt_q == 3'd7) begin
            state_q <= WAIT;
          end
        end
        WAIT: begin
          if (accept) recv_cnt_q <= recv_cnt_q + 3'd1;
          if (last_word) begin
            state_q      <= DONE;
            ifill_done_q <= !fill_sel_q;
            dfill_done_q <= fill_sel_q;
          end
        end
        DONE: begin
          state_q      <= IDLE;
          ifill_done_q <= 1'b0;
          dfill_done_q <= 1'b0;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign mem_en     = mem_en_q;
  assign mem_addr   = mem_addr_q;
  assign fill_we    = accept;
  assign fill_sel   = fill_sel_q;
  assign fill_idx   = recv_cnt_q;
  assign fill_data  = mem_data;
  assign ifill_done = ifill_done_q;
  assign dfill_done = dfill_done_q;
  assign busy       = (state_q != IDLE);

endmodule

// File: tb/tb_cache_fill_arbiter.sv
// Scoreboard bench for cache_fill_arbiter: expected issues, fill writes and done
// pulses are queued when a fill is requested and popped as the DUT produces them.
module tb_cache_fill_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        imiss_req = 1'b0;
  logic [15:0] imiss_addr = 16'h0000;
  logic        dmiss_req = 1'b0;
  logic [15:0] dmiss_addr = 16'h0000;
  logic        mem_data_valid = 1'b0;
  logic [15:0] mem_data = 16'h0000;
  logic        mem_en;
  logic [15:0] mem_addr;
  logic        fill_we;
  logic        fill_sel;
  logic [2:0]  fill_idx;
  logic [15:0] fill_data;
  logic        ifill_done;
  logic        dfill_done;
  logic        busy;

  cache_fill_arbiter dut (
    .clk            (clk),
    .rst            (rst),
    .imiss_req      (imiss_req),
    .imiss_addr     (imiss_addr),
    .dmiss_req      (dmiss_req),
    .dmiss_addr     (dmiss_addr),
    .mem_en         (mem_en),
    .mem_addr       (mem_addr),
    .mem_data_valid (mem_data_valid),
    .mem_data       (mem_data),
    .fill_we        (fill_we),
    .fill_sel       (fill_sel),
    .fill_idx       (fill_idx),
    .fill_data      (fill_data),
    .ifill_done     (ifill_done),
    .dfill_done     (dfill_done),
    .busy           (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] addr;
    int          ready;
  } pend_t;

  pend_t       pend_q[$];
  logic [15:0] exp_addr_q[$];
  logic [19:0] exp_fill_q[$];
  logic        exp_done_q[$];

  int n_checks = 0;
  int n_fail   = 0;
  int cyc        = 0;
  int last_ready = 0;
  int done_cnt   = 0;
  int fill_cnt   = 0;
  bit irregular  = 1'b0;
  bit stray      = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [15:0] mem_word(input logic [15:0] a);
    return a ^ 16'h5A3C;
  endfunction

  task automatic expect_fill(input logic sel, input logic [15:0] addr);
    logic [15:0] base;
    logic [15:0] a;
    base = addr & 16'hFFF0;
    for (int k = 0; k < 8; k++) begin
      a = base + 16'(2 * k);
      exp_addr_q.push_back(a);
      exp_fill_q.push_back({sel, 3'(k), mem_word(a)});
    end
    exp_done_q.push_back(sel);
  endtask

  // Returns at negedge+2 of the cycle in which done_cnt reached target.
  task automatic wait_done(input int target);
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      #2;
      if (done_cnt >= target) return;
    end
    check("done_timeout", done_cnt, target);
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    #3;
    rst = 1'b1;
    pend_q.delete();
    exp_addr_q.delete();
    exp_fill_q.delete();
    exp_done_q.delete();
    last_ready = 0;
    #1;
    check("rst_async_outs",
          {mem_en, mem_addr, fill_we, ifill_done, dfill_done, busy, fill_sel, fill_idx}, 0);
    @(posedge clk);
    @(negedge clk);
    #3;
    rst = 1'b0;
  endtask

  // Memory model and scoreboard monitor in one process: drive the returned
  // word at negedge, then sample outputs 1 time unit later.
  initial begin
    logic s;
    int   r;
    forever begin
      @(negedge clk);
      cyc++;
      if (stray) begin
        mem_data_valid = 1'b1;
        mem_data       = 16'hDEAD;
        stray          = 1'b0;
      end else if (pend_q.size() > 0 && pend_q[0].ready <= cyc) begin
        mem_data_valid = 1'b1;
        mem_data       = mem_word(pend_q[0].addr);
        void'(pend_q.pop_front());
      end else begin
        mem_data_valid = 1'b0;
        mem_data       = 16'($urandom);
      end
      #1;
      if (rst) continue;
      if (mem_en) begin
        if (exp_addr_q.size() == 0) check("mem_en_extra", mem_en, 0);
        else check("mem_addr", mem_addr, exp_addr_q.pop_front());
        if (irregular) begin
          r = last_ready + 1 + int'($urandom_range(0, 3));
          if (r < cyc + 1) r = cyc + 1;
          if (mem_addr[3:1] == 3'd7 && r < cyc + 6) r = cyc + 6;
        end else begin
          r = cyc + 4;
        end
        last_ready = r;
        pend_q.push_back('{addr: mem_addr, ready: r});
      end else begin
        check("mem_addr_off", mem_addr, 0);
      end
      if (fill_we) begin
        fill_cnt++;
        if (exp_fill_q.size() == 0) check("fill_we_extra", fill_we, 0);
        else check("fill_sel_idx_data", {fill_sel, fill_idx, fill_data}, exp_fill_q.pop_front());
      end
      if (ifill_done || dfill_done) begin
        done_cnt++;
        if (exp_done_q.size() == 0) check("done_extra", {ifill_done, dfill_done}, 0);
        else begin
          s = exp_done_q.pop_front();
          check("done_pulse", {ifill_done, dfill_done}, {~s, s});
        end
      end
      if (!busy) check("idle_quiet", {mem_en, fill_we}, 0);
    end
  end

  initial begin
    int   tgt;
    int   start;
    logic rr_sel [4];

    // Reset state
    repeat (3) @(negedge clk);
    #2;
    check("reset_outs",
          {mem_en, mem_addr, fill_we, ifill_done, dfill_done, busy, fill_sel, fill_idx}, 0);
    rst = 1'b0;

    // Single I miss, 4-cycle memory
    expect_fill(1'b0, 16'h1234);
    imiss_addr = 16'h1234;
    imiss_req  = 1'b1;
    tgt = done_cnt + 1;
    wait_done(tgt);
    imiss_req = 1'b0;
    @(negedge clk);
    #2;
    check("busy_after_ifill", busy, 0);

    // Simultaneous: D first, one IDLE cycle, then I
    expect_fill(1'b1, 16'h8008);
    expect_fill(1'b0, 16'h0040);
    imiss_addr = 16'h0040;
    dmiss_addr = 16'h8008;
    imiss_req  = 1'b1;
    dmiss_req  = 1'b1;
    tgt = done_cnt + 1;
    wait_done(tgt);
    dmiss_req = 1'b0;
    @(negedge clk);
    #2;
    check("gap_idle_busy", busy, 0);
    @(negedge clk);
    #2;
    check("regrant_busy", busy, 1);
    tgt = done_cnt + 1;
    wait_done(tgt);
    imiss_req = 1'b0;

    // Both held across four fills
    pulse_reset();
`ifdef FILL_RR_EN
    rr_sel = '{1'b1, 1'b0, 1'b1, 1'b0};
`else
    rr_sel = '{1'b1, 1'b1, 1'b1, 1'b1};
`endif
    imiss_addr = 16'h2002;
    dmiss_addr = 16'h4446;
    for (int k = 0; k < 4; k++)
      expect_fill(rr_sel[k], rr_sel[k] ? 16'h4446 : 16'h2002);
    imiss_req = 1'b1;
    dmiss_req = 1'b1;
    tgt = done_cnt + 4;
    wait_done(tgt);
    imiss_req = 1'b0;
    dmiss_req = 1'b0;
    repeat (2) @(negedge clk);

    // Irregular memory, then a stray valid while idle
    irregular = 1'b1;
    expect_fill(1'b1, 16'hBEEF);
    dmiss_addr = 16'hBEEF;
    dmiss_req  = 1'b1;
    tgt = done_cnt + 1;
    wait_done(tgt);
    dmiss_req = 1'b0;
    stray = 1'b1;
    repeat (3) @(negedge clk);
    expect_fill(1'b0, 16'h7FFE);
    imiss_addr = 16'h7FFE;
    imiss_req  = 1'b1;
    tgt = done_cnt + 1;
    wait_done(tgt);
    imiss_req = 1'b0;
    irregular = 1'b0;
    repeat (2) @(negedge clk);

    // Reset after the 3rd returned word of a D fill, then re-request
    expect_fill(1'b1, 16'h5550);
    dmiss_addr = 16'h5550;
    dmiss_req  = 1'b1;
    start = fill_cnt;
    for (int i = 0; i < 100 && fill_cnt < start + 3; i++) begin
      @(negedge clk);
      #2;
    end
    check("third_word_seen", fill_cnt, start + 3);
    @(posedge clk);
    tgt = done_cnt;
    dmiss_req = 1'b0;
    pulse_reset();
    repeat (6) @(negedge clk);
    check("no_done_after_rst", done_cnt, tgt);
    expect_fill(1'b1, 16'h5550);
    dmiss_req = 1'b1;
    tgt = done_cnt + 1;
    wait_done(tgt);
    dmiss_req = 1'b0;
    repeat (3) @(negedge clk);

    check("addr_q_empty", exp_addr_q.size(), 0);
    check("fill_q_empty", exp_fill_q.size(), 0);
    check("done_q_empty", exp_done_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
